// File: rtl/tmds_channel_pipe_if.sv
// Pixel-side bus of one TMDS channel: period/mode selection and payload in, encoded symbol out.
interface tmds_channel_pipe_if #(
  parameter int DISP_WIDTH = 5
);
  logic [7:0]                   video_data;
  logic [3:0]                   data_island_data;
  logic [1:0]                   control_data;
  logic [2:0]                   mode;
  logic [9:0]                   tmds;
  logic signed [DISP_WIDTH-1:0] disparity;
  logic                         mode_err;

  modport master (
    output video_data, data_island_data, control_data, mode,
    input  tmds, disparity, mode_err
  );

  modport slave (
    input  video_data, data_island_data, control_data, mode,
    output tmds, disparity, mode_err
  );
endinterface

// File: rtl/tmds_channel_pipe.sv
// Two-stage TMDS channel encoder (video 8b/10b, TERC4, guard bands, control).
// Latency 2 cycles, one symbol per cycle, no backpressure.
module tmds_channel_pipe #(
  parameter int CN         = 0,
  parameter bit DVI_OUTPUT = 1'b0,
  parameter int DISP_WIDTH = 5
) (
  input  logic                 clk_pixel,
  input  logic                 reset,
  tmds_channel_pipe_if.slave   bus
);

  localparam logic [2:0] M_CTRL   = 3'd0;
  localparam logic [2:0] M_VIDEO  = 3'd1;
  localparam logic [2:0] M_VGUARD = 3'd2;
  localparam logic [2:0] M_ISLAND = 3'd3;
  localparam logic [2:0] M_IGUARD = 3'd4;

  localparam logic [9:0] CTRL_00  = 10'b1101010100;
  localparam logic [9:0] GUARD_HI = 10'b0100110011;
  localparam logic [9:0] GUARD_LO = 10'b1011001100;
  localparam logic signed [DISP_WIDTH-1:0] TWO = DISP_WIDTH'(2);

  function automatic logic [9:0] ctrl_code(input logic [1:0] c);
    case (c)
      2'b00:   ctrl_code = CTRL_00;
      2'b01:   ctrl_code = 10'b0010101011;
      2'b10:   ctrl_code = 10'b0101010100;
      default: ctrl_code = 10'b1010101011;
    endcase
  endfunction

  function automatic logic [9:0] terc4(input logic [3:0] d);
    case (d)
      4'h0:    terc4 = 10'b1010011100;
      4'h1:    terc4 = 10'b1001100011;
      4'h2:    terc4 = 10'b1011100100;
      4'h3:    terc4 = 10'b1011100010;
      4'h4:    terc4 = 10'b0101110001;
      4'h5:    terc4 = 10'b0100011110;
      4'h6:    terc4 = 10'b0110001110;
      4'h7:    terc4 = 10'b0100111100;
      4'h8:    terc4 = 10'b1011001100;
      4'h9:    terc4 = 10'b0100111001;
      4'hA:    terc4 = 10'b0110011100;
      4'hB:    terc4 = 10'b1011000110;
      4'hC:    terc4 = 10'b1010001110;
      4'hD:    terc4 = 10'b1001110001;
      4'hE:    terc4 = 10'b0101100011;
      default: terc4 = 10'b1011000011;
    endcase
  endfunction

  // Stage 1 state
  logic [2:0] mode_s1_q, mode_s1_d;
  logic [1:0] ctrl_s1_q, ctrl_s1_d;
  logic [3:0] din_s1_q,  din_s1_d;
  logic [8:0] qm_s1_q,   qm_s1_d;
  logic [3:0] n1q_s1_q,  n1q_s1_d;

  // Stage 2 state
  logic [9:0]                   tmds_q, tmds_d;
  logic signed [DISP_WIDTH-1:0] cnt_q, cnt_d;
  logic                         mode_err_q, mode_err_d;

  logic [3:0] n1_data;
  logic       use_xnor;

  always_comb begin
    mode_s1_d = bus.mode;
    ctrl_s1_d = bus.control_data;
    din_s1_d  = bus.data_island_data;

    n1_data = '0;
    for (int i = 0; i < 8; i++) n1_data = n1_data + {3'b000, bus.video_data[i]};
    use_xnor = (n1_data > 4'd4) || (n1_data == 4'd4 && !bus.video_data[0]);

    qm_s1_d    = '0;
    qm_s1_d[0] = bus.video_data[0];
    for (int i = 1; i < 8; i++)
      qm_s1_d[i] = use_xnor ? ~(qm_s1_d[i-1] ^ bus.video_data[i])
                            :  (qm_s1_d[i-1] ^ bus.video_data[i]);
    qm_s1_d[8] = ~use_xnor;

    n1q_s1_d = '0;
    for (int i = 0; i < 8; i++) n1q_s1_d = n1q_s1_d + {3'b000, qm_s1_d[i]};
  end

  logic                         qm8;
  logic signed [DISP_WIDTH-1:0] n1s, n0s;

  always_comb begin
    tmds_d     = ctrl_code(ctrl_s1_q);
    cnt_d      = '0;
    mode_err_d = 1'b0;
    qm8        = qm_s1_q[8];
    n1s        = DISP_WIDTH'(n1q_s1_q);
    n0s        = DISP_WIDTH'(4'd8 - n1q_s1_q);

    case (mode_s1_q)
      M_CTRL: ;
      M_VIDEO: begin
        if (cnt_q == '0 || n1q_s1_q == 4'd4) begin
          tmds_d = {~qm8, qm8, qm8 ? qm_s1_q[7:0] : ~qm_s1_q[7:0]};
          cnt_d  = qm8 ? (cnt_q + n1s - n0s) : (cnt_q + n0s - n1s);
        end else if ((!cnt_q[DISP_WIDTH-1] && n1q_s1_q > 4'd4) ||
                     ( cnt_q[DISP_WIDTH-1] && n1q_s1_q < 4'd4)) begin
          // Inverting the payload pulls the running disparity back toward zero
          tmds_d = {1'b1, qm8, ~qm_s1_q[7:0]};
          cnt_d  = cnt_q + (qm8 ? TWO : '0) + n0s - n1s;
        end else begin
          tmds_d = {1'b0, qm8, qm_s1_q[7:0]};
          cnt_d  = cnt_q + n1s - n0s - (qm8 ? '0 : TWO);
        end
      end
      M_VGUARD: if (!DVI_OUTPUT) tmds_d = (CN == 1) ? GUARD_HI : GUARD_LO;
      M_ISLAND: if (!DVI_OUTPUT) tmds_d = terc4(din_s1_q);
      M_IGUARD: if (!DVI_OUTPUT) tmds_d = (CN == 0) ? terc4({2'b11, ctrl_s1_q}) : GUARD_HI;
      default:  mode_err_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      mode_s1_q  <= M_CTRL;
      ctrl_s1_q  <= '0;
      din_s1_q   <= '0;
      qm_s1_q    <= '0;
      n1q_s1_q   <= '0;
      tmds_q     <= CTRL_00;
      cnt_q      <= '0;
      mode_err_q <= 1'b0;
    end else begin
      mode_s1_q  <= mode_s1_d;
      ctrl_s1_q  <= ctrl_s1_d;
      din_s1_q   <= din_s1_d;
      qm_s1_q    <= qm_s1_d;
      n1q_s1_q   <= n1q_s1_d;
      tmds_q     <= tmds_d;
      cnt_q      <= cnt_d;
      mode_err_q <= mode_err_d;
    end
  end

  assign bus.tmds      = tmds_q;
  assign bus.disparity = cnt_q;
  assign bus.mode_err  = mode_err_q;

endmodule

// File: tb/tb_tmds_channel_pipe.sv
// Directed bench: three encoder builds (CN0, CN1, CN2+DVI) driven in lockstep.
module tb_tmds_channel_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] m_r;
  logic [7:0] vd_r;
  logic [3:0] di_r;
  logic [1:0] c_r;

  int checks = 0;
  int errors = 0;

  logic [9:0] terc [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

  tmds_channel_pipe_if #(.DISP_WIDTH(5)) bus0 ();
  tmds_channel_pipe_if #(.DISP_WIDTH(5)) bus1 ();
  tmds_channel_pipe_if #(.DISP_WIDTH(5)) bus2 ();

  assign bus0.mode = m_r;  assign bus0.video_data = vd_r;
  assign bus0.data_island_data = di_r;  assign bus0.control_data = c_r;
  assign bus1.mode = m_r;  assign bus1.video_data = vd_r;
  assign bus1.data_island_data = di_r;  assign bus1.control_data = c_r;
  assign bus2.mode = m_r;  assign bus2.video_data = vd_r;
  assign bus2.data_island_data = di_r;  assign bus2.control_data = c_r;

  tmds_channel_pipe #(.CN(0), .DVI_OUTPUT(1'b0), .DISP_WIDTH(5)) u0 (
    .clk_pixel(clk), .reset(rst), .bus(bus0));
  tmds_channel_pipe #(.CN(1), .DVI_OUTPUT(1'b0), .DISP_WIDTH(5)) u1 (
    .clk_pixel(clk), .reset(rst), .bus(bus1));
  tmds_channel_pipe #(.CN(2), .DVI_OUTPUT(1'b1), .DISP_WIDTH(5)) u2 (
    .clk_pixel(clk), .reset(rst), .bus(bus2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_sym(input string tag, input logic [9:0] et, input int ed, input logic ee);
    chk({tag, ".tmds"}, 16'(bus0.tmds), 16'(et));
    chk({tag, ".disp"}, 16'(bus0.disparity), 16'(ed));
    chk({tag, ".err"},  16'(bus0.mode_err), 16'(ee));
  endtask

  // Present one input set, clock it in, and settle away from the edge
  task automatic step(input logic r, input logic [2:0] m, input logic [7:0] vd,
                      input logic [3:0] di, input logic [1:0] c);
    rst = r; m_r = m; vd_r = vd; di_r = di; c_r = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; m_r = 3'd1; vd_r = 8'h00; di_r = 4'h0; c_r = 2'b00;

    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'd1, 8'h00, 4'h0, 2'b00);
      chk_sym("reset", 10'b1101010100, 0, 1'b0);
    end

    step(1'b0, 3'd1, 8'h00, 4'h0, 2'b00);
    chk_sym("release", 10'b1101010100, 0, 1'b0);
    step(1'b0, 3'd1, 8'h00, 4'h0, 2'b00);
    chk_sym("v00_1", 10'b0100000000, -8, 1'b0);
    step(1'b0, 3'd1, 8'h00, 4'h0, 2'b00);
    chk_sym("v00_2", 10'b1111111111, 2, 1'b0);
    step(1'b0, 3'd0, 8'h00, 4'h0, 2'b00);
    chk_sym("v00_3", 10'b0100000000, -6, 1'b0);
    step(1'b0, 3'd1, 8'h00, 4'h0, 2'b00);
    chk_sym("ctrl_gap", 10'b1101010100, 0, 1'b0);
    step(1'b0, 3'd1, 8'hFF, 4'h0, 2'b00);
    chk_sym("post_gap", 10'b0100000000, -8, 1'b0);
    step(1'b0, 3'd1, 8'h55, 4'h0, 2'b00);
    chk_sym("vFF", 10'b0011111111, -2, 1'b0);
    step(1'b0, 3'd6, 8'h00, 4'h0, 2'b01);
    chk_sym("v55", 10'b0100110011, -2, 1'b0);
    step(1'b0, 3'd0, 8'h00, 4'h0, 2'b11);
    chk_sym("illegal", 10'b0010101011, 0, 1'b1);

    for (int i = 0; i <= 16; i++) begin
      step(1'b0, 3'd3, 8'h00, 4'(i), 2'b10);
      if (i == 0) begin
        chk_sym("ctrl11", 10'b1010101011, 0, 1'b0);
      end else begin
        chk_sym($sformatf("terc%0d", i - 1), terc[i-1], 0, 1'b0);
        if (i == 1) begin
          chk("dvi_island.tmds", 16'(bus2.tmds), 16'(10'b0101010100));
          chk("dvi_island.err",  16'(bus2.mode_err), 16'(1'b0));
        end
      end
    end

    step(1'b0, 3'd4, 8'h00, 4'h0, 2'b10);
    step(1'b0, 3'd2, 8'h00, 4'h0, 2'b10);
    chk("iguard_cn0", 16'(bus0.tmds), 16'(10'b0101100011));
    chk("iguard_cn1", 16'(bus1.tmds), 16'(10'b0100110011));
    chk("iguard_dvi", 16'(bus2.tmds), 16'(10'b0101010100));
    chk("iguard_dvi_err", 16'(bus2.mode_err), 16'(1'b0));
    step(1'b0, 3'd0, 8'h00, 4'h0, 2'b10);
    chk("vguard_cn0", 16'(bus0.tmds), 16'(10'b1011001100));
    chk("vguard_cn1", 16'(bus1.tmds), 16'(10'b0100110011));
    chk("vguard_dvi", 16'(bus2.tmds), 16'(10'b0101010100));

    step(1'b0, 3'd1, 8'h00, 4'h0, 2'b00);
    chk_sym("ctrl10", 10'b0101010100, 0, 1'b0);
    step(1'b1, 3'd1, 8'h00, 4'h0, 2'b00);
    chk_sym("mid_reset", 10'b1101010100, 0, 1'b0);
    step(1'b0, 3'd1, 8'h00, 4'h0, 2'b00);
    chk_sym("mid_reset_flush", 10'b1101010100, 0, 1'b0);
    step(1'b0, 3'd1, 8'h00, 4'h0, 2'b00);
    chk_sym("after_reset", 10'b0100000000, -8, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
